// File: rtl/des_pkg.sv
// Shared types and sizing helpers for the serial deserializer.
// Holds the FSM state encoding, counter-width function and default word width.
package des_pkg;

  localparam int DES_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } des_state_t;

  // Bit counter must index 0..WIDTH-1; never narrower than one bit.
  function automatic int des_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out register built as a chain of enabled flip-flops.
// New bits enter at the MSB and walk toward bit 0, giving LSB-first word assembly.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg;
  logic [WIDTH-1:0] stage_next;

  assign stage_next = {sin, stage_reg[WIDTH-1:1]};

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stage_reg[gi] <= 1'b0;
        end else if (shift_en) begin
          stage_reg[gi] <= stage_next[gi];
        end
      end
    end
  endgenerate

  assign q = stage_reg;

endmodule

// File: rtl/serial_deserializer.sv
// Start-bit framed, LSB-first serial-to-parallel converter with a valid/ready word output,
// sticky overrun flag and busy indicator. Define DESERIALIZER_PARITY_CHECK_EN for even-parity checking.
module serial_deserializer
  import des_pkg::*;
#(
  parameter int WIDTH = DES_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = des_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  des_state_t       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             overrun_reg, overrun_next;
  logic             busy_reg;
  logic             shift_en;
  logic             commit;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sipo_q;

  assign shift_en = (state_reg == SHIFT) && din_en;

  sipo_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .clk     (clk),
    .reset   (reset),
    .shift_en(shift_en),
    .sin     (din),
    .q       (sipo_q)
  );

`ifdef DESERIALIZER_PARITY_CHECK_EN
  logic parity_fail;
  logic parity_err_reg;
`else
  logic unused_lsb;
  assign unused_lsb = sipo_q[0];
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    // The word as it will look once the bit on din is shifted in this edge.
    word       = {din, sipo_q[WIDTH-1:1]};
`ifdef DESERIALIZER_PARITY_CHECK_EN
    parity_fail = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (din_en && din) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (din_en) begin
          if (cnt_reg == LAST_BIT) begin
            cnt_next = '0;
`ifdef DESERIALIZER_PARITY_CHECK_EN
            state_next = PARITY;
`else
            state_next = IDLE;
            commit     = 1'b1;
`endif
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
`ifdef DESERIALIZER_PARITY_CHECK_EN
      PARITY: begin
        if (din_en) begin
          state_next = IDLE;
          word       = sipo_q;
          if ((^sipo_q) == din) begin
            commit = 1'b1;
          end else begin
            parity_fail = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output handshake: a commit into a full, unaccepted buffer is dropped and flagged.
  always_comb begin
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    overrun_next    = overrun_reg;
    if (commit) begin
      if (!dout_valid_reg || dout_ready) begin
        dout_next       = word;
        dout_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (dout_valid_reg && dout_ready) begin
      dout_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      overrun_reg    <= overrun_next;
      busy_reg       <= (state_next != IDLE);
    end
  end

`ifdef DESERIALIZER_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err_reg <= 1'b0;
    end else begin
      parity_err_reg <= parity_fail;
    end
  end
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign overrun    = overrun_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed testbench for serial_deserializer (WIDTH=8): framing, gaps, backpressure,
// simultaneous accept, mid-frame reset and, with DESERIALIZER_PARITY_CHECK_EN, parity.
module tb_serial_deserializer;

  logic       clk;
  logic       reset;
  logic       din;
  logic       din_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  serial_deserializer #(
    .WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_en    (din_en),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are observed on the next falling edge.
  task automatic drive_cycle(input logic d, input logic en, input logic rdy);
    din        = d;
    din_en     = en;
    dout_ready = rdy;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] w, input bit gapped, input logic rdy_last);
    logic rdy;
    drive_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (gapped) drive_cycle(~w[i], 1'b0, 1'b0);
`ifdef DESERIALIZER_PARITY_CHECK_EN
      rdy = 1'b0;
`else
      rdy = (i == 7) ? rdy_last : 1'b0;
`endif
      drive_cycle(w[i], 1'b1, rdy);
    end
`ifdef DESERIALIZER_PARITY_CHECK_EN
    drive_cycle(^w, 1'b1, rdy_last);
`endif
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 1'b0; din_en = 1'b0; dout_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({dout, dout_valid, busy, overrun, parity_err} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state: got dout=%h valid=%b busy=%b ovr=%b perr=%b, want all 0",
               dout, dout_valid, busy, overrun, parity_err);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] w = 8'hA5;
    // Zero bits while idle must not start a frame.
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_zero_ignored: busy=%b want 0", busy);
    end
    drive_cycle(1'b1, 1'b1, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: busy=%b want 1", busy);
    end
    for (int i = 0; i < 7; i++) begin
      drive_cycle(w[i], 1'b1, 1'b0);
      total++;
      if (busy !== 1'b1 || dout_valid !== 1'b0 || parity_err !== 1'b0) begin
        bad++;
        $display("FAIL busy_mid_frame bit%0d: busy=%b valid=%b perr=%b want 1 0 0",
                 i, busy, dout_valid, parity_err);
      end
    end
    drive_cycle(w[7], 1'b1, 1'b0);
`ifdef DESERIALIZER_PARITY_CHECK_EN
    drive_cycle(1'b0, 1'b1, 1'b0);
`endif
    total++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_frame: dout=%h valid=%b busy=%b want a5 1 0", dout, dout_valid, busy);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b0 || dout !== 8'hA5) begin
      bad++;
      $display("FAIL basic_consume: valid=%b dout=%h want 0 a5", dout_valid, dout);
    end
    $display("test_basic done: dout=%h", dout);
  endtask

  task automatic test_gapped();
    pulse_reset();
    drive_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(~i[0], 1'b0, 1'b0);
      total++;
      if (busy !== 1'b1 || dout_valid !== 1'b0) begin
        bad++;
        $display("FAIL gap_hold bit%0d: busy=%b valid=%b want 1 0", i, busy, dout_valid);
      end
      drive_cycle((i == 0 || i == 2 || i == 5 || i == 7), 1'b1, 1'b0);
    end
`ifdef DESERIALIZER_PARITY_CHECK_EN
    drive_cycle(1'b0, 1'b1, 1'b0);
`endif
    total++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL gapped_frame: dout=%h valid=%b want a5 1", dout, dout_valid);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    $display("test_gapped done: dout=%h", dout);
  endtask

  task automatic test_backpressure();
    send_frame(8'h3C, 1'b0, 1'b0);
    total++;
    if (dout !== 8'h3C || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL bp_first: dout=%h valid=%b ovr=%b want 3c 1 0", dout, dout_valid, overrun);
    end
    send_frame(8'hC3, 1'b0, 1'b0);
    total++;
    if (dout !== 8'h3C || dout_valid !== 1'b1 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL bp_overrun: dout=%h valid=%b ovr=%b want 3c 1 1", dout, dout_valid, overrun);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b0 || dout !== 8'h3C || overrun !== 1'b1) begin
      bad++;
      $display("FAIL bp_drain: valid=%b dout=%h ovr=%b want 0 3c 1", dout_valid, dout, overrun);
    end
    $display("test_backpressure done: ovr=%b", overrun);
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    total++;
    if (dout !== 8'hC3 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL simultaneous: dout=%h valid=%b ovr=%b want c3 1 0", dout, dout_valid, overrun);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    $display("test_simultaneous done: dout=%h", dout);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w = 8'hFF;
    drive_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(w[i], 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({dout, dout_valid, busy, overrun, parity_err} !== 12'h000) begin
      bad++;
      $display("FAIL midframe_reset: dout=%h valid=%b busy=%b ovr=%b perr=%b want all 0",
               dout, dout_valid, busy, overrun, parity_err);
    end
    @(negedge clk);
    reset = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    total++;
    if (dout !== 8'h5A || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_frame: dout=%h valid=%b ovr=%b want 5a 1 0", dout, dout_valid, overrun);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    $display("test_reset_midframe done: dout=%h", dout);
  endtask

`ifdef DESERIALIZER_PARITY_CHECK_EN
  task automatic test_parity();
    logic [7:0] w = 8'hA5;
    pulse_reset();
    drive_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive_cycle(w[i], 1'b1, 1'b0);
    total++;
    if (busy !== 1'b1 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL parity_state: busy=%b valid=%b want 1 0", busy, dout_valid);
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    total++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1 || parity_err !== 1'b0) begin
      bad++;
      $display("FAIL parity_ok: dout=%h valid=%b perr=%b want a5 1 0", dout, dout_valid, parity_err);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive_cycle(w[i], 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    total++;
    if (parity_err !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL parity_bad: perr=%b valid=%b busy=%b want 1 0 0", parity_err, dout_valid, busy);
    end
    drive_cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (parity_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL parity_pulse_width: perr=%b ovr=%b want 0 0", parity_err, overrun);
    end
    $display("test_parity done");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_simultaneous();
    test_reset_midframe();
`ifdef DESERIALIZER_PARITY_CHECK_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Downstream consumer of the master-slave DFF stage: takes the registered serial bit stream (DFF q) and assembles it into parallel words.
- Detects a start bit, shifts in WIDTH data bits LSB-first, and presents each word on a valid/ready output handshake.
- Provides a sticky overrun flag and a busy indicator.
- Sits between the bit-level flip-flop chain and any word-level consumer (register file, ALU operand latch).

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2..32).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  1  serial data bit, driven from the upstream DFF q.
- din_en  input  1  sample strobe; din is sampled only on cycles where din_en=1.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- busy  output  1  a frame is in progress (state != IDLE).
- overrun  output  1  sticky flag: a completed word was dropped.
- parity_err  output  1  one-cycle pulse on parity mismatch (tied 0 without macro).

Behaviour:
- Reset (reset=0, async): state=IDLE, shift reg=0, bit count=0, dout=0, dout_valid=0, busy=0, overrun=0, parity_err=0. Reset mid-frame discards the partial word.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE: on din_en=1 && din=1 (start bit), go to SHIFT with count=0. din=0 samples are ignored.
- SHIFT: each din_en=1 cycle shifts din in at the MSB end (LSB-first framing, so the first data bit ends at dout[0]) and increments count. Cycles with din_en=0 hold all state.
- Last data bit sampled (count reaches WIDTH-1 with din_en=1): go to IDLE, or to PARITY if enabled. A new start bit is accepted the very next din_en cycle.
- Word commit happens on the same edge that samples the last bit (or the parity bit), so dout and dout_valid are visible the following cycle. Latency is 0 cycles after the final sampling edge.
- Commit rules:
  - dout_valid=0: load dout, set dout_valid=1.
  - dout_valid=1 && dout_ready=1 (simultaneous): load new word, dout_valid stays 1, no overrun.
  - dout_valid=1 && dout_ready=0: new word dropped, dout unchanged, overrun<=1.
- Handshake: dout_valid and dout stay stable until dout_ready=1. On the cycle with dout_valid && dout_ready and no commit, dout_valid<=0 and dout holds its last value.
- overrun clears only on reset.
- busy = (state != IDLE), registered with the state.
- Counter width is $clog2(WIDTH). Count wraps to 0 on return to IDLE.

Optional Feature:
- Macro: DESERIALIZER_PARITY_CHECK_EN.
- Defined:
  - After the WIDTH data bits, state PARITY samples one more din_en bit as even parity over the data.
  - Match: commit per the rules above.
  - Mismatch: word discarded, parity_err=1 for exactly one cycle, dout_valid and overrun unaffected.
  - Either way, return to IDLE.
- Not defined: no PARITY state, commit occurs straight from SHIFT, parity_err is constant 0.

Decomposition:
- Package des_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the function computing counter width;
  - the DES_DEFAULT_WIDTH constant.
- One sub-module, sipo_shift_reg (WIDTH, clk, reset, shift_en, sin, q[WIDTH-1:0]): a pure serial-in/parallel-out register built as a DFF chain. The FSM, handshake and flags stay in the top.

Test Plan:
- Reset then frame: start=1, bits 1,0,1,0,0,1,0,1 with din_en=1 every cycle -> dout=8'hA5, dout_valid=1 the cycle after the 8th bit; busy=1 during the frame, 0 after.
- Gapped strobes: the same 0xA5 frame with din_en=0 on alternate cycles -> identical dout=8'hA5; state holds on din_en=0 cycles.
- Backpressure: frames 0x3C then 0xC3 back-to-back, dout_ready=0 -> dout stays 8'h3C, overrun=1. Then dout_ready=1 for one cycle -> dout_valid=0.
- Simultaneous: dout_ready=1 on the same edge the 0xC3 frame commits while 0x3C is valid -> dout=8'hC3, dout_valid=1, overrun=0.
- Reset mid-frame: drive reset=0 after 4 data bits -> all outputs 0 immediately. A new 0x5A frame then yields dout=8'h5A with no residue.
- Parity (macro defined): 0xA5 + parity 0 -> commit. 0xA5 + parity 1 -> parity_err one-cycle pulse, dout_valid stays 0.
